timer_sequencer: RTL and testbench

//  Initiator side of the timer load interface: drives value/valid/enable into a timer and consumes its trigger.

---
 rtl/timer_sequencer_pkg.sv | 24 ++
 rtl/timer_sequencer_if.sv | 32 +++
 rtl/timer_sequencer_seq_table.sv | 31 +++
 rtl/timer_sequencer.sv | 178 +++++++++++++++++
 tb/tb_timer_sequencer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_sequencer_pkg.sv
// Shared constants for the timer sequencer: default geometry, FSM encodings and the flush reload value.
package timer_sequencer_pkg;

    localparam int WIDTH_DEF  = 5;
    localparam int DEPTH_DEF  = 4;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ARM   = 3'd2,
        WAIT  = 3'd3,
        FLUSH = 3'd4
    } seq_state_t;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ARM   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    localparam logic [31:0] FLUSH_VALUE = 32'd0;

endpackage

// File: rtl/timer_sequencer_if.sv
// Config bus plus timer load/trigger signals; master is the sequencer, slave is its environment.
interface timer_sequencer_if #(
    parameter int WIDTH  = 5,
    parameter int ADDR_W = 2
);
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [WIDTH-1:0]  cfg_data;
    logic [ADDR_W:0]   cfg_len;
    logic              start;
    logic              stop;
    logic              loop_en;
    logic              trigger;
    logic [WIDTH-1:0]  value;
    logic              valid;
    logic              enable;
    logic              busy;
    logic              step;
    logic [ADDR_W-1:0] idx;
    logic              done;
    logic              cfg_err;

    modport master (
        input  cfg_we, cfg_addr, cfg_data, cfg_len, start, stop, loop_en, trigger,
        output value, valid, enable, busy, step, idx, done, cfg_err
    );

    modport slave (
        output cfg_we, cfg_addr, cfg_data, cfg_len, start, stop, loop_en, trigger,
        input  value, valid, enable, busy, step, idx, done, cfg_err
    );
endinterface

// File: rtl/timer_sequencer_seq_table.sv
// Reload value table: one write port, combinational read, cleared by reset.
module seq_table #(
    parameter int WIDTH  = 5,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Table storage write port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/timer_sequencer.sv
// Plays a table of reload values into a timer, reloading after each trigger, with optional looping.
module timer_sequencer
    import timer_sequencer_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic               clk,
    input logic               reset_n,
    timer_sequencer_if.master bus
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              loop_q, loop_d;
    logic              cfg_err_q, cfg_err_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic              valid_q, valid_d;
    logic              enable_q, enable_d;
    logic              busy_q, busy_d;
    logic              step_q, step_d;
    logic              done_q, done_d;

    logic [ADDR_W:0]   len_in_s;
    logic              last_s;
    logic              wr_en_s;
    logic [WIDTH-1:0]  rdata_s;
    logic [2:0]        adv_state_s;
    logic [ADDR_W-1:0] adv_idx_s;
    logic              adv_done_s;

    assign len_in_s = (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;
    assign last_s   = (({1'b0, idx_q} + (ADDR_W+1)'(1'b1)) >= len_q);
    // The table is frozen outside IDLE so playback always sees a stable set of values.
    assign wr_en_s  = bus.cfg_we && (state_q == S_IDLE);

    seq_table #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_table (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (wr_en_s),
        .waddr_i (bus.cfg_addr),
        .wdata_i (bus.cfg_data),
        .raddr_i (idx_d),
        .rdata_o (rdata_s)
    );

    // Where to go once the current entry is completed or skipped
    always_comb begin
        adv_idx_s   = idx_q;
        adv_state_s = S_IDLE;
        adv_done_s  = 1'b0;
        if (!last_s) begin
            adv_idx_s   = idx_q + ADDR_W'(1'b1);
            adv_state_s = S_LOAD;
        end else if (loop_q) begin
            adv_idx_s   = '0;
            adv_state_s = S_LOAD;
        end else begin
            adv_done_s  = 1'b1;
        end
    end

    // Sequencer FSM next state and pulse outputs
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        loop_d    = loop_q;
        cfg_err_d = cfg_err_q | (bus.cfg_we & (state_q != S_IDLE));
        step_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.cfg_len == '0)) begin
                    done_d    = 1'b1;
                end else if (bus.start) begin
                    state_d   = S_LOAD;
                    idx_d     = '0;
                    len_d     = len_in_s;
                    loop_d    = bus.loop_en;
                    cfg_err_d = 1'b0;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_LOAD: begin
                // value_q still holds table[idx_q] while in LOAD; zero entries are skipped.
                if (bus.stop) begin
                    state_d = S_FLUSH;
                end else if (value_q == '0) begin
                    step_d  = 1'b1;
                    state_d = adv_state_s;
                    idx_d   = adv_idx_s;
                    done_d  = adv_done_s;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (bus.stop) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.stop) begin
                    state_d = S_FLUSH;
                end else if (bus.trigger) begin
                    step_d  = 1'b1;
                    state_d = adv_state_s;
                    idx_d   = adv_idx_s;
                    done_d  = adv_done_s;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_FLUSH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        valid_d  = (state_d == S_LOAD) || (state_d == S_FLUSH);
        enable_d = (state_d == S_ARM) || (state_d == S_WAIT);
        busy_d   = (state_d != S_IDLE);
    end

    assign value_d = (state_d == S_LOAD) ? rdata_s : WIDTH'(FLUSH_VALUE);

    // State, playback context and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            step_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            loop_q    <= loop_d;
            cfg_err_q <= cfg_err_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            enable_q  <= enable_d;
            busy_q    <= busy_d;
            step_q    <= step_d;
            done_q    <= done_d;
        end
    end

    assign bus.value   = value_q;
    assign bus.valid   = valid_q;
    assign bus.enable  = enable_q;
    assign bus.busy    = busy_q;
    assign bus.step    = step_q;
    assign bus.idx     = idx_q;
    assign bus.done    = done_q;
    assign bus.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Scoreboard bench for timer_sequencer: expected reloads are queued at start and matched against observed loads.
module tb_timer_sequencer;

    localparam int W  = 5;
    localparam int AW = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    timer_sequencer_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

    timer_sequencer #(.WIDTH(W), .DEPTH(4), .ADDR_W(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    int total = 0;
    int bad   = 0;

    logic [W-1:0]  exp_vals [$];
    logic [AW-1:0] exp_idx  [$];
    logic [W-1:0]  got_vals [$];
    logic [AW-1:0] got_idx  [$];
    int            got_cyc  [$];
    int n_step, n_done, n_trig, lat_bad, done_busy_bad, en_on_valid;

    task automatic write_entry(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic kick(input logic [AW:0] len, input logic lp);
        bus.cfg_len = len; bus.loop_en = lp; bus.start = 1'b1;
    endtask

    // Plays the timer role: fires trigger on the second enabled cycle (WAIT) and records loads.
    task automatic run_play(input int budget, input int max_trig, input bit end_on_done);
        bit pend = 1'b0;
        bit prev_en = 1'b0;
        got_vals.delete(); got_idx.delete(); got_cyc.delete();
        n_step = 0; n_done = 0; n_trig = 0; lat_bad = 0; done_busy_bad = 0; en_on_valid = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.stop = 1'b0; bus.trigger = 1'b0;
            if (pend && !(bus.valid || bus.done)) lat_bad++;
            pend = 1'b0;
            if (bus.valid) begin
                got_vals.push_back(bus.value); got_idx.push_back(bus.idx); got_cyc.push_back(c);
                if (bus.enable) en_on_valid++;
            end
            if (bus.step) n_step++;
            if (bus.done) begin
                n_done++;
                if (bus.busy) done_busy_bad++;
            end
            if (bus.done && end_on_done) break;
            if (bus.enable && prev_en && (n_trig < max_trig)) begin
                bus.trigger = 1'b1; n_trig++; pend = 1'b1;
            end
            prev_en = bus.enable;
        end
        bus.trigger = 1'b0;
    endtask

    task automatic test_reset;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_len = '0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0; bus.trigger = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.value, bus.valid, bus.enable, bus.busy, bus.step, bus.idx, bus.done, bus.cfg_err} !== 13'd0) begin
            bad++; $display("FAIL reset_outputs: got %0h want 0", {bus.value, bus.valid, bus.enable, bus.busy, bus.step, bus.idx, bus.done, bus.cfg_err});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.valid, bus.busy, bus.done} !== 3'b000) begin
            bad++; $display("FAIL reset_idle: got %b want 000", {bus.valid, bus.busy, bus.done});
        end
    endtask

    task automatic test_basic;
        logic [W-1:0] e, g;
        write_entry(2'd0, 5'd3); write_entry(2'd1, 5'd5); write_entry(2'd2, 5'd2); write_entry(2'd3, 5'd7);
        exp_vals.push_back(5'd3); exp_vals.push_back(5'd5); exp_vals.push_back(5'd2);
        kick(3'd3, 1'b0);
        run_play(40, 10, 1'b1);
        while (exp_vals.size() > 0) begin
            e = exp_vals.pop_front(); total++;
            if (got_vals.size() == 0) begin bad++; $display("FAIL basic_value: got none want %0d", e); end
            else begin
                g = got_vals.pop_front();
                if (g !== e) begin bad++; $display("FAIL basic_value: got %0d want %0d", g, e); end
            end
        end
        total++; if (got_vals.size() != 0) begin bad++; $display("FAIL basic_extra: got %0d extra loads want 0", got_vals.size()); end
        total++; if (got_cyc.size() == 0 || got_cyc[0] != 0) begin bad++; $display("FAIL basic_start_latency: first valid not in cycle after start, want cycle 0"); end
        total++; if (n_step != 3) begin bad++; $display("FAIL basic_steps: got %0d want 3", n_step); end
        total++; if (n_done != 1) begin bad++; $display("FAIL basic_done: got %0d want 1", n_done); end
        total++; if (lat_bad != 0) begin bad++; $display("FAIL basic_trig_latency: got %0d late reloads want 0", lat_bad); end
        total++; if (done_busy_bad != 0 || bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_drop: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_loop;
        logic [W-1:0] e, g;
        logic [AW-1:0] ei, gi;
        write_entry(2'd0, 5'd4); write_entry(2'd1, 5'd6);
        for (int i = 0; i < 6; i++) begin
            exp_vals.push_back((i % 2 == 0) ? 5'd4 : 5'd6);
            exp_idx.push_back((i % 2 == 0) ? 2'd0 : 2'd1);
        end
        kick(3'd2, 1'b1);
        run_play(25, 5, 1'b0);
        while (exp_vals.size() > 0) begin
            e = exp_vals.pop_front(); ei = exp_idx.pop_front(); total++;
            if (got_vals.size() == 0) begin bad++; $display("FAIL loop_value: got none want %0d", e); end
            else begin
                g = got_vals.pop_front(); gi = got_idx.pop_front();
                if (g !== e || gi !== ei) begin bad++; $display("FAIL loop_value: got val=%0d idx=%0d want val=%0d idx=%0d", g, gi, e, ei); end
            end
        end
        total++; if (n_done != 0) begin bad++; $display("FAIL loop_no_done: got %0d want 0", n_done); end
        total++; if (bus.enable !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL loop_waiting: got en=%b busy=%b want 1 1", bus.enable, bus.busy); end
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        total++;
        if ({bus.valid, bus.enable, bus.busy, bus.done} !== 4'b1010 || bus.value !== 5'd0) begin
            bad++; $display("FAIL loop_flush: got v/e/b/d=%b value=%0d want 1010 value=0", {bus.valid, bus.enable, bus.busy, bus.done}, bus.value);
        end
        @(negedge clk);
        total++;
        if ({bus.valid, bus.busy, bus.done} !== 3'b000) begin bad++; $display("FAIL loop_idle: got %b want 000", {bus.valid, bus.busy, bus.done}); end
    endtask

    task automatic test_skip;
        logic [W-1:0] e, g;
        write_entry(2'd0, 5'd0); write_entry(2'd1, 5'd9);
        exp_vals.push_back(5'd0); exp_vals.push_back(5'd9);
        kick(3'd2, 1'b0);
        run_play(40, 10, 1'b1);
        while (exp_vals.size() > 0) begin
            e = exp_vals.pop_front(); total++;
            if (got_vals.size() == 0) begin bad++; $display("FAIL skip_value: got none want %0d", e); end
            else begin
                g = got_vals.pop_front();
                if (g !== e) begin bad++; $display("FAIL skip_value: got %0d want %0d", g, e); end
            end
        end
        total++; if (got_cyc.size() < 2 || got_cyc[1] - got_cyc[0] != 1) begin bad++; $display("FAIL skip_back_to_back: second load not in cycle after zero entry"); end
        total++; if (n_step != 2) begin bad++; $display("FAIL skip_steps: got %0d want 2", n_step); end
        total++; if (n_done != 1) begin bad++; $display("FAIL skip_done: got %0d want 1", n_done); end
        total++; if (en_on_valid != 0) begin bad++; $display("FAIL skip_enable: got %0d loads with enable want 0", en_on_valid); end
    endtask

    task automatic test_arm_stop;
        write_entry(2'd0, 5'd5);
        kick(3'd1, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        total++; if (bus.enable !== 1'b1 || bus.valid !== 1'b0) begin bad++; $display("FAIL arm_state: got en=%b valid=%b want 1 0", bus.enable, bus.valid); end
        bus.trigger = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
        total++;
        if ({bus.step, bus.enable, bus.valid, bus.done} !== 4'b0100) begin
            bad++; $display("FAIL arm_trigger_ignored: got s/e/v/d=%b want 0100", {bus.step, bus.enable, bus.valid, bus.done});
        end
        bus.stop = 1'b1; bus.trigger = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0; bus.trigger = 1'b0;
        total++;
        if ({bus.valid, bus.enable, bus.step, bus.done, bus.busy} !== 5'b10001 || bus.value !== 5'd0) begin
            bad++; $display("FAIL stop_wins: got v/e/s/d/b=%b value=%0d want 10001 value=0", {bus.valid, bus.enable, bus.step, bus.done, bus.busy}, bus.value);
        end
        @(negedge clk);
        total++; if ({bus.busy, bus.done, bus.step} !== 3'b000) begin bad++; $display("FAIL stop_idle: got %b want 000", {bus.busy, bus.done, bus.step}); end
    endtask

    task automatic test_cfg_err;
        logic [W-1:0] e, g;
        write_entry(2'd0, 5'd1); write_entry(2'd1, 5'd2); write_entry(2'd2, 5'd3); write_entry(2'd3, 5'd4);
        exp_vals.push_back(5'd2); exp_vals.push_back(5'd3); exp_vals.push_back(5'd4);
        kick(3'd4, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        total++; if (bus.valid !== 1'b1 || bus.value !== 5'd1) begin bad++; $display("FAIL err_first_load: got valid=%b value=%0d want 1 1", bus.valid, bus.value); end
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_data = 5'd31;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", bus.cfg_err); end
        run_play(60, 10, 1'b1);
        while (exp_vals.size() > 0) begin
            e = exp_vals.pop_front(); total++;
            if (got_vals.size() == 0) begin bad++; $display("FAIL err_value: got none want %0d", e); end
            else begin
                g = got_vals.pop_front();
                if (g !== e) begin bad++; $display("FAIL err_value: got %0d want %0d", g, e); end
            end
        end
        total++; if (n_done != 1 || bus.cfg_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got done=%0d err=%b want 1 1", n_done, bus.cfg_err); end
        bus.cfg_len = 3'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        total++; if ({bus.done, bus.busy, bus.valid} !== 3'b100) begin bad++; $display("FAIL zero_len_start: got d/b/v=%b want 100", {bus.done, bus.busy, bus.valid}); end
        @(negedge clk);
        exp_vals.push_back(5'd1); exp_vals.push_back(5'd2);
        kick(3'd2, 1'b0);
        run_play(40, 10, 1'b1);
        while (exp_vals.size() > 0) begin
            e = exp_vals.pop_front(); total++;
            if (got_vals.size() == 0) begin bad++; $display("FAIL err_readback: got none want %0d", e); end
            else begin
                g = got_vals.pop_front();
                if (g !== e) begin bad++; $display("FAIL err_readback: got %0d want %0d", g, e); end
            end
        end
        total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL err_cleared: got %b want 0", bus.cfg_err); end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] e, g;
        write_entry(2'd0, 5'd8);
        kick(3'd1, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.enable !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL mid_wait: got en=%b busy=%b want 1 1", bus.enable, bus.busy); end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({bus.value, bus.valid, bus.enable, bus.busy, bus.step, bus.idx, bus.done, bus.cfg_err} !== 13'd0) begin
            bad++; $display("FAIL mid_reset_async: got %0h want 0", {bus.value, bus.valid, bus.enable, bus.busy, bus.step, bus.idx, bus.done, bus.cfg_err});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) exp_vals.push_back(5'd0);
        kick(3'd7, 1'b0);
        run_play(40, 10, 1'b1);
        while (exp_vals.size() > 0) begin
            e = exp_vals.pop_front(); total++;
            if (got_vals.size() == 0) begin bad++; $display("FAIL mid_cleared_table: got none want %0d", e); end
            else begin
                g = got_vals.pop_front();
                if (g !== e) begin bad++; $display("FAIL mid_cleared_table: got %0d want %0d", g, e); end
            end
        end
        total++; if (got_vals.size() != 0) begin bad++; $display("FAIL mid_clamp_extra: got %0d extra loads want 0", got_vals.size()); end
        total++; if (n_step != 4 || n_done != 1) begin bad++; $display("FAIL mid_clamp_steps: got steps=%0d done=%0d want 4 1", n_step, n_done); end
        total++; if (en_on_valid != 0) begin bad++; $display("FAIL mid_enable: got %0d want 0", en_on_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loop();
        test_skip();
        test_arm_stop();
        test_cfg_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
